fp_unit_arbiter: RTL

FP_UNIT_ARBITER -- requirements
Module: fp_unit_arbiter

---
 rtl/fp_unit_arbiter_pkg.sv | 16 +
 rtl/fp_unit_arbiter_if.sv | 46 ++++
 rtl/fp_unit_arbiter_rr_pick.sv | 29 ++
 rtl/fp_unit_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/fp_unit_arbiter_pkg.sv
// Shared types and default sizing for the FP unit arbiter.
package fp_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SEND_A,
    S_SEND_B,
    S_WAIT_Z,
    S_RETURN
  } state_e;

endpackage

// File: rtl/fp_unit_arbiter_if.sv
// Requester, response and shared-unit handshakes of the FP unit arbiter.
// master = arbiter side, slave = requesters plus the shared unit.
interface fp_arb_if
  import fp_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0][W-1:0] req_a;
  logic [NREQ-1:0][W-1:0] req_b;
  logic [NREQ-1:0]        req_stb;
  logic [NREQ-1:0]        req_ack;

  logic [W-1:0]           resp_z;
  logic [NREQ-1:0]        resp_stb;
  logic [NREQ-1:0]        resp_ack;

  logic [W-1:0]           unit_a;
  logic [W-1:0]           unit_b;
  logic                   unit_a_stb;
  logic                   unit_b_stb;
  logic                   unit_a_ack;
  logic                   unit_b_ack;

  logic [W-1:0]           unit_z;
  logic                   unit_z_stb;
  logic                   unit_z_ack;

  logic                   busy;
  logic [IW-1:0]          grant_id;

  modport master (
    input  req_a, req_b, req_stb, resp_ack, unit_a_ack, unit_b_ack, unit_z, unit_z_stb,
    output req_ack, resp_z, resp_stb, unit_a, unit_b, unit_a_stb, unit_b_stb, unit_z_ack,
           busy, grant_id
  );

  modport slave (
    output req_a, req_b, req_stb, resp_ack, unit_a_ack, unit_b_ack, unit_z, unit_z_stb,
    input  req_ack, resp_z, resp_stb, unit_a, unit_b, unit_a_stb, unit_b_stb, unit_z_ack,
           busy, grant_id
  );

endinterface

// File: rtl/fp_unit_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above last_i, wrapping.
// Fixed priority is obtained by tying last_i to NREQ-1.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_i,
  output logic            valid_o,
  output logic [IW-1:0]   idx_o
);

  logic [IW-1:0] cand;

  // Scan farthest-first so the nearest candidate after last_i overwrites the rest.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last_i) + k) % NREQ);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Arbitrates NREQ requesters onto one shared FP add/sub unit, one operation at a time.
// Define FP_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module fp_unit_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input logic      clk,
  input logic      rst,
  fp_arb_if.master bus
);

  localparam int IW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [IW-1:0]   grantId_q, grantId_d;
  logic [W-1:0]    opA_q, opA_d;
  logic [W-1:0]    opB_q, opB_d;
  logic [W-1:0]    result_q, result_d;
  logic [IW-1:0]   pickLast;
  logic            pickValid;
  logic [IW-1:0]   pickIdx;
  logic [NREQ-1:0] ownerMask;

`ifdef FP_ARB_FIXED_PRIO_EN
  assign pickLast = IW'(NREQ - 1);
`else
  logic [IW-1:0] lastGrant_q, lastGrant_d;

  assign pickLast = lastGrant_q;

  // Only a completed response moves the rotation, so aborted grants do not count.
  always_comb begin
    lastGrant_d = lastGrant_q;
    if (state_q == S_RETURN && bus.resp_ack[grantId_q]) lastGrant_d = grantId_q;
  end

  always_ff @(posedge clk) begin
    if (rst) lastGrant_q <= IW'(NREQ - 1);
    else     lastGrant_q <= lastGrant_d;
  end
`endif

  rr_pick #(.NREQ(NREQ)) picker (
    .req_i   (bus.req_stb),
    .last_i  (pickLast),
    .valid_o (pickValid),
    .idx_o   (pickIdx)
  );

  always_comb begin
    state_d   = state_q;
    grantId_d = grantId_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (pickValid) begin
          grantId_d = pickIdx;
          opA_d     = bus.req_a[pickIdx];
          opB_d     = bus.req_b[pickIdx];
          state_d   = S_GRANT;
        end
      end
      S_GRANT:  state_d = S_SEND_A;
      S_SEND_A: if (bus.unit_a_ack) state_d = S_SEND_B;
      S_SEND_B: if (bus.unit_b_ack) state_d = S_WAIT_Z;
      S_WAIT_Z: begin
        if (bus.unit_z_stb) begin
          result_d = bus.unit_z;
          state_d  = S_RETURN;
        end
      end
      S_RETURN: if (bus.resp_ack[grantId_q]) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grantId_q <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      grantId_q <= grantId_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      result_q  <= result_d;
    end
  end

  assign ownerMask = NREQ'(1) << grantId_q;

  always_comb begin
    bus.req_ack    = '0;
    bus.resp_stb   = '0;
    bus.unit_a_stb = (state_q == S_SEND_A);
    bus.unit_b_stb = (state_q == S_SEND_B);
    bus.unit_z_ack = (state_q == S_WAIT_Z);
    if (state_q == S_GRANT)  bus.req_ack  = ownerMask;
    if (state_q == S_RETURN) bus.resp_stb = ownerMask;
  end

  assign bus.unit_a   = opA_q;
  assign bus.unit_b   = opB_q;
  assign bus.resp_z   = result_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.grant_id = grantId_q;

endmodule
